// File: rtl/wiring_scan_ctrl.sv
// Wiring scan controller: walks the gates of one circuit layer, queries the
// external Add/Mul wiring predicates for each gate, and streams one entry per
// wired gate through a single-entry valid/ready output slot.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, layer_in         scan request and layer to scan (sampled in IDLE)
//   busy, done, err         scan in progress, completion pulse, sticky conflict
//   wire_gate, wire_layer   current gate/layer driven to the predicates
//   add_conn, is_add        Add predicate response (combinational)
//   mul_conn, is_mul        Mul predicate response (combinational)
//   out_valid, out_ready    output slot handshake
//   out_gate, out_conn,
//   out_is_mul              output entry payload
//   entry_count             entries emitted in the current or last scan
module wiring_scan_ctrl #(
  parameter int unsigned LN_LAYER = 1,
  parameter int unsigned G        = 3,
  parameter int unsigned NUM_BITS = 3,
  parameter int unsigned LN_G     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LN_LAYER:0]     layer_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LN_G:0]         wire_gate,
  output logic [LN_LAYER:0]     wire_layer,
  input  logic [NUM_BITS:0]     add_conn,
  input  logic                  is_add,
  input  logic [NUM_BITS:0]     mul_conn,
  input  logic                  is_mul,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LN_G:0]         out_gate,
  output logic [NUM_BITS:0]     out_conn,
  output logic                  out_is_mul,
  output logic [LN_G+1:0]       entry_count
);

  localparam int unsigned LW = LN_LAYER + 1;
  localparam int unsigned GW = LN_G + 1;
  localparam int unsigned CW = NUM_BITS + 1;
  localparam int unsigned EW = LN_G + 2;

  localparam logic [GW-1:0] G_LAST = GW'(G - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic [GW-1:0]   g;
  logic [LW-1:0]   layer_q;

  logic            slot_free_c;
  logic            one_hot_c;
  logic            both_c;
  logic            load_c;
  logic            advance_c;
  logic [CW-1:0]   sel_conn_c;

  // Slot is free if empty or being consumed this cycle.
  always_comb begin
    slot_free_c = 1'b0;
    one_hot_c   = 1'b0;
    both_c      = 1'b0;
    load_c      = 1'b0;
    advance_c   = 1'b0;
    sel_conn_c  = '0;
    slot_free_c = !out_valid || out_ready;
    one_hot_c   = is_add ^ is_mul;
    both_c      = is_add && is_mul;
    load_c      = one_hot_c && slot_free_c;
    // A wired gate advances only once its entry is loaded; unwired gates
    // advance unconditionally.
    advance_c   = load_c || (!is_add && !is_mul);
    sel_conn_c  = is_mul ? mul_conn : add_conn;
  end

  assign wire_gate  = g;
  assign wire_layer = layer_q;

  // Controller FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      g           <= '0;
      layer_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      out_valid   <= 1'b0;
      out_gate    <= '0;
      out_conn    <= '0;
      out_is_mul  <= 1'b0;
      entry_count <= '0;
    end else begin
      done <= 1'b0;
      // Consumed entry leaves the slot unless reloaded below.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            layer_q     <= layer_in;
            entry_count <= '0;
            err         <= 1'b0;
            g           <= '0;
            busy        <= 1'b1;
            state       <= SCAN;
          end
        end

        SCAN: begin
          if (both_c) begin
            // Conflicting predicates: drop the gate and abort the scan.
            err   <= 1'b1;
            state <= DRAIN;
          end else begin
            if (load_c) begin
              out_valid   <= 1'b1;
              out_gate    <= g;
              out_conn    <= sel_conn_c;
              out_is_mul  <= is_mul;
              entry_count <= entry_count + EW'(1);
            end
            if (advance_c) begin
              if (g == G_LAST) begin
                state <= DRAIN;
              end else begin
                g <= g + GW'(1);
              end
            end
          end
        end

        DRAIN: begin
          if (slot_free_c) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/wiring_scan_ctrl.md
WIRING_SCAN_CTRL -- requirements
Module: wiring_scan_ctrl

Interface
REQ-001 SHALL have parameters: LN_LAYER, default 1, layer index width minus 1; G, default 3, gates per layer; NUM_BITS, default 3, connected-gate index width minus 1; LN_G, default 1, gate index width minus 1.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  scan request.
- layer_in  in  LN_LAYER+1  layer to scan.
- busy  out  1  scan in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error, both predicates true.
- wire_gate  out  LN_G+1  currGate to the Add/Mul wiring predicates.
- wire_layer  out  LN_LAYER+1  currLayer to the predicates.
- add_conn  in  NUM_BITS+1  connGate from the Add predicate.
- is_add  in  1  isAdd from the Add predicate.
- mul_conn  in  NUM_BITS+1  connGate from the Mul predicate.
- is_mul  in  1  isMul from the Mul predicate.
- out_valid  out  1  entry available.
- out_ready  in  1  consumer accepts entry.
- out_gate  out  LN_G+1  gate index of entry.
- out_conn  out  NUM_BITS+1  connected gate of entry.
- out_is_mul  out  1  entry type: 1 = mul, 0 = add.
- entry_count  out  LN_G+2  entries emitted in the current or last scan.

Function
REQ-003 SHALL implement FSM states IDLE, SCAN, DRAIN.
REQ-004 IDLE: start=1 at a clock edge SHALL latch layer_in, clear entry_count and err, set gate counter g=0, and enter SCAN.
REQ-005 start SHALL be ignored outside IDLE.
REQ-006 wire_layer SHALL equal the latched layer, and wire_gate SHALL equal g.
- Both are registered values, stable for the whole SCAN cycle.
- The predicates are combinational, so their outputs SHALL be sampled in the same cycle.
REQ-007 The single-entry output slot is "free" when out_valid=0, or when out_valid=1 and out_ready=1 in that cycle.
REQ-008 SCAN, exactly one of is_add/is_mul high, slot free:
- Load the slot: out_gate=g; out_conn=add_conn or mul_conn; out_is_mul=is_mul.
- Set out_valid=1 and increment entry_count.
- Advance g.
REQ-009 SCAN, exactly one predicate high, slot not free: SHALL hold g and wire_gate, and SHALL NOT modify the slot (stall).
REQ-010 SCAN, neither predicate high: SHALL advance g with no entry, independent of slot state.
REQ-011 SCAN, both predicates high: SHALL set err=1, drop that gate, and go to DRAIN without scanning further gates (abort).
REQ-012 Advancing from g=G-1 SHALL enter DRAIN instead of incrementing; g SHALL never exceed G-1.
REQ-013 DRAIN: when the slot becomes empty SHALL return to IDLE and pulse done=1 for exactly the first IDLE cycle.
REQ-014 out_valid=1 SHALL hold out_gate/out_conn/out_is_mul stable until out_ready=1; the slot clears when out_ready=1 and it is not reloaded in the same cycle.
REQ-015 Sustained throughput SHALL be one gate per cycle with out_ready held high.
REQ-016 busy SHALL be 1 in SCAN and DRAIN, 0 in IDLE.
REQ-017 entry_count and err SHALL hold their values after done until the next accepted start.
REQ-018 G=1 SHALL be supported: SCAN lasts one cycle, then DRAIN.

Reset
REQ-019 rst_n=0 SHALL asynchronously force:
- State IDLE.
- g=0 and latched layer=0.
- busy, done, err, out_valid = 0.
- out_gate, out_conn, out_is_mul, entry_count = 0.
REQ-020 Reset asserted mid-scan SHALL discard any pending entry without a handshake and SHALL NOT pulse done.
REQ-021 After rst_n deasserts, the first start SHALL be accepted at the first clock edge.

Verification
REQ-022 Bench SHALL cover these directed scenarios (G=3 unless stated):
- Nominal: start, layer_in=1; g0 add conn 5, g1 mul conn 2, g2 none; out_ready=1 -> entries (0,5,add), (1,2,mul) on consecutive cycles; done pulse after DRAIN; entry_count=2; err=0.
- Backpressure: all gates add; out_ready=0 for 4 cycles after the first out_valid -> entry (0,...) held stable, wire_gate stays 1; then 3 entries in order; entry_count=3.
- Conflict: g1 is_add=is_mul=1 -> err=1; only entry g0 emitted; done pulses; no scan of g2.
- Empty layer: no predicate true -> no out_valid; done pulses; entry_count=0.
- Reset mid-scan at g=1 with out_valid=1 -> out_valid=0 and busy=0 immediately; no done; next start scans from g=0.
- Start while busy and G=1: second start ignored; G=1 add entry emitted; single done pulse.
